// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader.
// Holds the default memory geometry and the loader state encoding so the
// memory and the loader agree on size and address width.
package imem_pkg;

    // Instruction memory size in bytes and the matching byte address width.
    localparam int IMEM_DEPTH_DEF = 256;
    localparam int ADDR_W_DEF     = 8;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } ldr_state_e;

endpackage : imem_pkg

// File: rtl/imem_loader.sv
// Purpose : streams 32-bit program words into a byte-wide instruction memory, big-endian.
// Latency : 1 accept cycle + 4 byte-write cycles per word (one word per 5 cycles sustained).
// Backpr. : word_ready is high only in the accept cycle; words are held off during writes.
//
// Ports
//   clk, rst                 : single clock, asynchronous active-low reset
//   start                    : one-cycle pulse, restarts loading at byte address 0 (IDLE/DONE only)
//   word_valid/data/last     : incoming program words, handshaken with word_ready
//   mem_we/addr/wdata        : registered byte write port to the instruction memory
//   busy, done, overflow     : load status; overflow means memory filled before word_last
//   checksum                 : modulo-256 sum of bytes written
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to enable the running checksum;
// otherwise the checksum port is tied to zero.
module imem_loader
    import imem_pkg::*;
#(
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              word_valid,
    input  logic [31:0]       word_data,
    input  logic              word_last,
    output logic              word_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [7:0]        checksum
);

    ldr_state_e        state_q,     state_d;
    logic [ADDR_W-1:0] addr_q,      addr_d;      // byte address of the next word
    logic [1:0]        byte_cnt_q,  byte_cnt_d;  // byte lane currently on the write port
    logic [23:0]       word_q,      word_d;      // lower three bytes; the top byte goes out on accept
    logic              last_q,      last_d;
    logic              overflow_q,  overflow_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] next_addr;

    // Byte address following the one on the write port, modulo the memory size.
    assign next_addr = (mem_addr_q == ADDR_W'(IMEM_DEPTH - 1)) ? '0
                                                                : mem_addr_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        byte_cnt_d  = byte_cnt_q;
        word_d      = word_q;
        last_d      = last_q;
        overflow_d  = overflow_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_ACCEPT;
                    addr_d     = '0;
                    overflow_d = 1'b0;
                end
            end

            ST_ACCEPT: begin
                // The first byte is loaded into the write port on the accept
                // edge so the four strobes follow back-to-back.
                if (word_valid) begin
                    state_d     = ST_WRITE;
                    word_d      = word_data[23:0];
                    last_d      = word_last;
                    byte_cnt_d  = 2'd0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = word_data[31:24];
                end
            end

            ST_WRITE: begin
                if (byte_cnt_q != 2'd3) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = next_addr;
                    case (byte_cnt_q)
                        2'd0:    mem_wdata_d = word_q[23:16];
                        2'd1:    mem_wdata_d = word_q[15:8];
                        default: mem_wdata_d = word_q[7:0];
                    endcase
                end else begin
                    // Fourth byte is on the port; decide where the load goes next.
                    // A captured last takes priority, so an exact fill is not an overflow.
                    addr_d = next_addr;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (next_addr == '0) begin
                        state_d    = ST_DONE;
                        overflow_d = 1'b1;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            byte_cnt_q  <= 2'd0;
            word_q      <= '0;
            last_q      <= 1'b0;
            overflow_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            last_q      <= last_d;
            overflow_q  <= overflow_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] checksum_q, checksum_d;
    logic       checksum_clr;

    // Cleared by the same start that restarts the address counter.
    assign checksum_clr = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Each byte is folded in on the edge that ends its strobe cycle.
    always_comb begin
        checksum_d = checksum_q;
        if (checksum_clr) begin
            checksum_d = '0;
        end else if (mem_we_q) begin
            checksum_d = checksum_q + mem_wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 8'h00;
`endif

    assign word_ready = (state_q == ST_ACCEPT);
    assign busy       = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign done       = (state_q == ST_DONE);
    assign overflow   = overflow_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte write log, handshake log, and
// scenario tasks with hand-computed expectations.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_last;
    logic        word_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [7:0]  checksum;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          ready_cnt = 0;
    logic [7:0]  wr_addr[$];
    logic [7:0]  wr_data[$];
    int          hs_cyc[$];
    logic [31:0] stim_words[64];

    imem_loader #(
        .IMEM_DEPTH (256),
        .ADDR_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_ready (word_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .checksum   (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Log write strobes and handshakes away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (word_valid && word_ready) hs_cyc.push_back(cyc);
        if (word_ready) ready_cnt = ready_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // start is raised just after an edge and sampled on the next one.
    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents stim_words[0..n-1] with word_valid held high throughout.
    task automatic send_stream(input int n, input bit last_final, input bit start_in_write);
        int waitc;
        word_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            word_data = stim_words[i];
            word_last = last_final && (i == n - 1);
            waitc = 0;
            while (!word_ready && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            if (!word_ready) begin
                n_checks++;
                $display("FAIL stream_ready_timeout word=%0d actual word_ready=0 required 1", i);
                word_valid = 1'b0;
                word_last  = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (start_in_write) begin
                start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL done_timeout actual done=0 required 1 after %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0; word_last = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, checksum} !== 29'd0)
            $display("FAIL reset_outputs actual=%h required 0",
                     {word_ready, mem_we, mem_addr, mem_wdata, busy, done, overflow, checksum});
        else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, word_ready, done} !== 3'b000)
            $display("FAIL reset_idle actual busy/ready/done=%b required 000", {busy, word_ready, done});
        else n_pass++;
    endtask

    task automatic test_single_word();
        int base;
        logic [7:0] exp_b[4];
        logic [7:0] exp_sum;
        exp_b = '{8'h20, 8'h08, 8'h00, 8'h05};
        base = wr_addr.size();
        stim_words[0] = 32'h2008_0005;
        pulse_start();
        n_checks++;
        if ({busy, word_ready} !== 2'b11)
            $display("FAIL single_accept actual busy/ready=%b required 11", {busy, word_ready});
        else n_pass++;
        send_stream(1, 1'b1, 1'b0);
        wait_done(20);
        n_checks++;
        if (wr_addr.size() - base !== 4)
            $display("FAIL single_count actual=%0d required 4", wr_addr.size() - base);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (wr_addr[base + k] !== 8'(k) || wr_data[base + k] !== exp_b[k])
                $display("FAIL single_byte%0d actual %h@%0d required %h@%0d",
                         k, wr_data[base + k], wr_addr[base + k], exp_b[k], k);
            else n_pass++;
        end
        n_checks++;
        if ({done, busy, overflow} !== 3'b100)
            $display("FAIL single_status actual done/busy/ovf=%b required 100", {done, busy, overflow});
        else n_pass++;
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_sum = 8'h2D;
`else
        exp_sum = 8'h00;
`endif
        n_checks++;
        if (checksum !== exp_sum)
            $display("FAIL single_checksum actual=%h required %h", checksum, exp_sum);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int base, h0, r0;
        logic [7:0] exp;
        stim_words[0] = 32'h1122_3344;
        stim_words[1] = 32'h5566_7788;
        stim_words[2] = 32'h99AA_BBCC;
        base = wr_addr.size();
        h0   = hs_cyc.size();
        r0   = ready_cnt;
        pulse_start();
        send_stream(3, 1'b1, 1'b0);
        wait_done(30);
        n_checks++;
        if (hs_cyc.size() - h0 !== 3)
            $display("FAIL b2b_handshakes actual=%0d required 3", hs_cyc.size() - h0);
        else n_pass++;
        if (hs_cyc.size() - h0 >= 3) begin
            for (int i = 1; i < 3; i++) begin
                n_checks++;
                if (hs_cyc[h0 + i] - hs_cyc[h0 + i - 1] !== 5)
                    $display("FAIL b2b_spacing%0d actual=%0d required 5",
                             i, hs_cyc[h0 + i] - hs_cyc[h0 + i - 1]);
                else n_pass++;
            end
        end
        n_checks++;
        if (ready_cnt - r0 !== 3)
            $display("FAIL b2b_ready_cycles actual=%0d required 3", ready_cnt - r0);
        else n_pass++;
        n_checks++;
        if (wr_addr.size() - base !== 12)
            $display("FAIL b2b_count actual=%0d required 12", wr_addr.size() - base);
        else n_pass++;
        for (int k = 0; k < 12; k++) begin
            exp = 8'(stim_words[k / 4] >> (8 * (3 - (k % 4))));
            n_checks++;
            if (wr_addr[base + k] !== 8'(k) || wr_data[base + k] !== exp)
                $display("FAIL b2b_byte%0d actual %h@%0d required %h@%0d",
                         k, wr_data[base + k], wr_addr[base + k], exp, k);
            else n_pass++;
        end
        n_checks++;
        if ({done, busy, overflow} !== 3'b100)
            $display("FAIL b2b_status actual done/busy/ovf=%b required 100", {done, busy, overflow});
        else n_pass++;
    endtask

    task automatic fill_stim();
        for (int i = 0; i < 64; i++)
            stim_words[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
    endtask

    task automatic test_overflow();
        int base, errs;
        fill_stim();
        base = wr_addr.size();
        pulse_start();
        send_stream(64, 1'b0, 1'b0);
        wait_done(30);
        n_checks++;
        if (wr_addr.size() - base !== 256)
            $display("FAIL ovf_count actual=%0d required 256", wr_addr.size() - base);
        else n_pass++;
        errs = 0;
        for (int k = 0; k < 256; k++)
            if (wr_addr[base + k] !== 8'(k) || wr_data[base + k] !== 8'(k)) errs++;
        n_checks++;
        if (errs !== 0) $display("FAIL ovf_bytes actual errors=%0d required 0", errs);
        else n_pass++;
        n_checks++;
        if ({done, busy, overflow} !== 3'b101)
            $display("FAIL ovf_status actual done/busy/ovf=%b required 101", {done, busy, overflow});
        else n_pass++;
        n_checks++;
        if (mem_addr !== 8'hFF)
            $display("FAIL ovf_last_addr actual=%h required ff", mem_addr);
        else n_pass++;
        // A word offered after the wrap must not be taken or written.
        word_valid = 1'b1;
        word_data  = 32'hDEAD_BEEF;
        repeat (10) @(negedge clk);
        n_checks++;
        if (wr_addr.size() - base !== 256 || word_ready !== 1'b0)
            $display("FAIL ovf_no_extra actual writes=%0d ready=%b required 256 0",
                     wr_addr.size() - base, word_ready);
        else n_pass++;
        word_valid = 1'b0;
    endtask

    task automatic test_exact_fill();
        int base;
        fill_stim();
        base = wr_addr.size();
        pulse_start();
        n_checks++;
        if ({overflow, done} !== 2'b00)
            $display("FAIL fill_start_clear actual ovf/done=%b required 00", {overflow, done});
        else n_pass++;
        send_stream(64, 1'b1, 1'b0);
        wait_done(30);
        n_checks++;
        if (wr_addr.size() - base !== 256)
            $display("FAIL fill_count actual=%0d required 256", wr_addr.size() - base);
        else n_pass++;
        n_checks++;
        if ({done, overflow} !== 2'b10)
            $display("FAIL fill_status actual done/ovf=%b required 10", {done, overflow});
        else n_pass++;
    endtask

    task automatic test_start_in_write();
        int base, errs;
        logic [7:0] exp_b[8];
        logic [7:0] exp_sum;
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h00, 8'h00, 8'h01};
        stim_words[0] = 32'h0102_0304;
        stim_words[1] = 32'hFF00_0001;
        base = wr_addr.size();
        pulse_start();
        send_stream(2, 1'b1, 1'b1);
        wait_done(30);
        n_checks++;
        if (wr_addr.size() - base !== 8)
            $display("FAIL siw_count actual=%0d required 8", wr_addr.size() - base);
        else n_pass++;
        errs = 0;
        for (int k = 0; k < 8; k++)
            if (wr_addr[base + k] !== 8'(k) || wr_data[base + k] !== exp_b[k]) errs++;
        n_checks++;
        if (errs !== 0) $display("FAIL siw_sequence actual errors=%0d required 0", errs);
        else n_pass++;
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_sum = 8'h0A;
`else
        exp_sum = 8'h00;
`endif
        n_checks++;
        if (checksum !== exp_sum)
            $display("FAIL siw_checksum actual=%h required %h", checksum, exp_sum);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n0, waitc;
        pulse_start();
        word_valid = 1'b1;
        word_data  = 32'hA1B2_C3D4;
        word_last  = 1'b0;
        waitc = 0;
        while (!word_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        @(posedge clk); #1;
        word_valid = 1'b0;
        @(posedge clk); #2;
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h01, 8'hB2})
            $display("FAIL rstmid_second_byte actual we=%b %h@%h required 1 b2@01",
                     mem_we, mem_wdata, mem_addr);
        else n_pass++;
        n0  = wr_addr.size();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_we, busy} !== 2'b00)
            $display("FAIL rstmid_immediate actual we/busy=%b required 00", {mem_we, busy});
        else n_pass++;
        n_checks++;
        if ({word_ready, done, overflow, mem_addr, mem_wdata} !== 19'd0)
            $display("FAIL rstmid_outputs actual=%h required 0",
                     {word_ready, done, overflow, mem_addr, mem_wdata});
        else n_pass++;
        word_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (wr_addr.size() !== n0 || {busy, done, word_ready} !== 3'b000)
            $display("FAIL rstmid_idle actual writes=%0d busy/done/ready=%b required %0d 000",
                     wr_addr.size(), {busy, done, word_ready}, n0);
        else n_pass++;
        word_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_exact_fill();
        test_start_in_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_imem_loader

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter IMEM_DEPTH, default 256, meaning instruction memory size in bytes.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning byte address width (log2 IMEM_DEPTH).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse, begins a load at byte address 0.
REQ-006 SHALL have port word_valid  input  1  word_data/word_last valid.
REQ-007 SHALL have port word_data  input  32  instruction word to store.
REQ-008 SHALL have port word_last  input  1  marks final word of the program.
REQ-009 SHALL have port word_ready  output  1  loader accepts a word this cycle.
REQ-010 SHALL have port mem_we  output  1  byte write strobe to instruction memory.
REQ-011 SHALL have port mem_addr  output  ADDR_W  byte write address.
REQ-012 SHALL have port mem_wdata  output  8  byte write data.
REQ-013 SHALL have port busy  output  1  load in progress; CPU held off while high.
REQ-014 SHALL have port done  output  1  load finished; held until next start.
REQ-015 SHALL have port overflow  output  1  memory filled before word_last.
REQ-016 SHALL have port checksum  output  8  running byte sum (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, ACCEPT, WRITE, DONE.
REQ-018 SHALL, in IDLE or DONE on start=1, clear address counter, done, overflow, checksum and enter ACCEPT next cycle.
REQ-019 SHALL ignore start in ACCEPT and WRITE.
REQ-020 SHALL drive word_ready=1 only in ACCEPT; word_valid is ignored in all other states.
REQ-021 SHALL, on word_valid&word_ready, capture word_data and word_last and enter WRITE; no word is dropped or duplicated.
REQ-022 SHALL, in WRITE, assert mem_we for exactly 4 consecutive cycles, big-endian: word[31:24] at addr, [23:16] at addr+1, [15:8] at addr+2, [7:0] at addr+3.
REQ-023 SHALL drive mem_we, mem_addr, mem_wdata directly from flops (no combinational path from inputs); mem_we=0 outside WRITE.
REQ-024 SHALL, after the 4th byte, go to DONE if captured last=1, else to DONE with overflow=1 if address counter wrapped to 0, else to ACCEPT.
REQ-025 SHALL sustain one word per 5 cycles with word_valid held high.
REQ-026 SHALL increment address modulo IMEM_DEPTH; a wrap never causes a further write.
REQ-027 SHALL assert busy in ACCEPT and WRITE only; done=1 only in DONE.
REQ-028 SHALL, when word_last arrives with the 64th word (fills memory exactly), end with done=1, overflow=0.

Reset
REQ-029 SHALL on rst=0 immediately force state IDLE, address 0, byte counter 0, and outputs word_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, checksum=0.
REQ-030 SHALL abort a load in progress on reset mid-operation; no write strobe is issued after rst falls.

Configuration
REQ-031 SHALL, with macro IMEM_LOADER_CHECKSUM_EN defined, update checksum to modulo-256 sum of every byte written, updated on the cycle after each mem_we.
REQ-032 SHALL, without IMEM_LOADER_CHECKSUM_EN, keep the checksum port present and tied to 0, with no adder logic.

Structure
REQ-033 SHALL take IMEM_DEPTH, ADDR_W defaults and the loader state enum from shared package imem_pkg, also used by the instruction memory.
REQ-034 SHALL be a single module; byte-lane selection is an inline mux, no sub-module.

Verification
REQ-035 Bench SHALL cover: start, one word 0x20080005 with last=1 -> writes 0x20@0,0x08@1,0x00@2,0x05@3, then done=1, busy=0, overflow=0.
REQ-036 Bench SHALL cover: 3 back-to-back words, valid held high -> word_ready high 1 cycle in 5, 12 strobes at addr 0..11, done after last.
REQ-037 Bench SHALL cover: 64 words, none with last -> 256 writes, addr wraps to 0, overflow=1, done=1, no 257th write.
REQ-038 Bench SHALL cover: rst driven low during 2nd byte of a word -> mem_we=0 and busy=0 immediately, state IDLE, no further writes.
REQ-039 Bench SHALL cover: start pulsed in WRITE -> ignored, address sequence unchanged; with IMEM_LOADER_CHECKSUM_EN, words 0x01020304,0xFF000001 last -> checksum 0x0A.
